// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_pkg
// Brief    : Opcode constants, NOP encoding and fetch FSM states.
// Revision : 1.0
// ============================================================================
package instruction_fetch_unit_pkg;

    localparam logic [6:0]  OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_reg
// Brief    : Program counter with reset value, +4 step and word-aligned load.
// Revision : 1.0
// ============================================================================
module fetch_pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_load_aligned;

    // Low two bits are cleared so the PC is always word aligned.
    assign w_load_aligned = load_pc & ~(XLEN'(3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= w_load_aligned;
        end else if (inc) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Single-outstanding fetch stage with redirect and stale-response drop.
// Revision : 1.0
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instruction,
    output logic [6:0]      dec_opcode,
    output logic [XLEN-1:0] dec_pc
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] w_pc;
    logic            w_pc_inc;
    logic            w_dec_load;
    logic            r_dec_valid;
    logic [XLEN-1:0] r_dec_instruction;
    logic [6:0]      r_dec_opcode;
    logic [XLEN-1:0] r_dec_pc;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_pc_inc),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .pc      (w_pc)
    );

    // Gated combinationally so a soon-to-be-replaced PC never reaches memory.
    assign imem_req_valid = (r_state == ST_REQ) && !redirect_valid && !rst;
    assign imem_req_addr  = w_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_inc     = 1'b0;
        w_dec_load   = 1'b0;
        if (redirect_valid) begin
            // A response arriving alongside the redirect is the one being discarded.
            unique case (r_state)
                ST_REQ:  w_state_next = ST_REQ;
                ST_WAIT: w_state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
                ST_DROP: w_state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
                ST_HOLD: w_state_next = ST_REQ;
                default: w_state_next = ST_REQ;
            endcase
        end else begin
            unique case (r_state)
                ST_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_dec_load   = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) begin
                        w_state_next = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (r_dec_valid && dec_ready) begin
                        w_pc_inc     = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
                default: w_state_next = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid       <= 1'b0;
            r_dec_instruction <= NOP_INSTR;
            r_dec_opcode      <= OPC_ITYPE;
            r_dec_pc          <= RESET_PC;
        end else if (redirect_valid) begin
            r_dec_valid <= 1'b0;
        end else if (w_dec_load) begin
            r_dec_valid       <= 1'b1;
            r_dec_instruction <= imem_rsp_data;
            r_dec_opcode      <= imem_rsp_data[6:0];
            r_dec_pc          <= w_pc;
        end else if (w_pc_inc) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign dec_valid       = r_dec_valid;
    assign dec_instruction = r_dec_instruction;
    assign dec_opcode      = r_dec_opcode;
    assign dec_pc          = r_dec_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Randomised scoreboard bench with a transaction-level fetch model.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instruction;
    logic [6:0]  dec_opcode;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .XLEN     (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instruction (dec_instruction),
        .dec_opcode      (dec_opcode),
        .dec_pc          (dec_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] words_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_count = 0;
    logic [31:0] last_hs_pc = '0;

    // Stimulus knobs (percent, reset in per mille)
    int unsigned p_ready = 100, p_dready = 100, p_redir = 0, p_spur = 0, p_rst = 0;
    int unsigned fixed_delay = 1;
    int          rst_cycles  = 3;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;

    // Memory and architectural model state
    bit          pending    = 1'b0;
    bit          pend_stale = 1'b0;
    int          cnt        = 0;
    logic [31:0] pend_pc    = '0;
    logic [31:0] pend_data  = '0;
    logic [31:0] model_pc   = TB_RESET_PC;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: all inputs change 1 time unit after the rising edge.
    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rst = (rst_cycles > 0) || ($urandom_range(0, 999) < p_rst);
            if (rst_cycles > 0) rst_cycles--;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = pend_data;
                end
            end else if ($urandom_range(0, 99) < p_spur) begin
                imem_rsp_valid = 1'b1;
            end
            imem_req_ready = !pending && ($urandom_range(0, 99) < p_ready);
            dec_ready      = ($urandom_range(0, 99) < p_dready);
            // Random redirects avoid coinciding with delivery of an already-dropped response.
            redirect_valid = force_redir ||
                             (($urandom_range(0, 99) < p_redir) && !(imem_rsp_valid && pend_stale));
            redirect_pc    = force_redir ? force_target : $urandom;
            force_redir    = 1'b0;
        end
    end

    // Reference model: predicts the effect of the coming edge from the interface rules.
    always @(negedge clk) begin
        logic [31:0] old_pc;
        bit          hs;
        old_pc = model_pc;
        if (rst) begin
            model_pc = TB_RESET_PC;
            exp_q.delete();
            if (pending) pend_stale = 1'b1;
            if (pending && imem_rsp_valid) pending = 1'b0;
        end else begin
            hs = (exp_q.size() > 0) && dec_ready;
            if (redirect_valid) begin
                model_pc = redirect_pc & 32'hFFFF_FFFC;
                if (!dec_ready) exp_q.delete();
            end else if (hs) begin
                model_pc = model_pc + 32'd4;
            end
            if (pending && imem_rsp_valid) begin
                if (!pend_stale && !redirect_valid) exp_q.push_back({pend_data, pend_pc});
                pending = 1'b0;
            end else if (pending && redirect_valid) begin
                pend_stale = 1'b1;
            end
            if (imem_req_valid && imem_req_ready) begin
                check32("req_addr", imem_req_addr, old_pc);
                pending    = 1'b1;
                pend_stale = 1'b0;
                pend_pc    = old_pc;
                cnt        = (fixed_delay != 0) ? int'(fixed_delay) : int'($urandom_range(1, 4));
                pend_data  = (words_q.size() > 0) ? words_q.pop_front() : $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each decode handshake and checks interface rules.
    bit          prev_hold = 1'b0;
    bit          pend_seen = 1'b0;
    logic [31:0] prev_instr, prev_pc;
    logic [6:0]  prev_opc;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            check32("req_valid_in_rst", {31'b0, imem_req_valid}, 32'd0);
            prev_hold = 1'b0;
            pend_seen = 1'b0;
        end else begin
            if (dec_valid) check32("req_while_dec", {31'b0, imem_req_valid}, 32'd0);
            if (redirect_valid) check32("req_while_redirect", {31'b0, imem_req_valid}, 32'd0);
            if (prev_hold) begin
                check32("stall_valid", {31'b0, dec_valid}, 32'd1);
                check32("stall_instr", dec_instruction, prev_instr);
                check32("stall_opcode", {25'b0, dec_opcode}, {25'b0, prev_opc});
                check32("stall_pc", dec_pc, prev_pc);
            end
            if (exp_q.size() > 0) begin
                if (pend_seen) check32("dec_valid_missing", {31'b0, dec_valid}, 32'd1);
                pend_seen = 1'b1;
            end else begin
                pend_seen = 1'b0;
            end
            if (dec_valid && dec_ready) begin
                hs_count++;
                last_hs_pc = dec_pc;
                if (exp_q.size() == 0) begin
                    check32("unexpected_dec", {31'b0, dec_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check32("dec_instruction", dec_instruction, e.instr);
                    check32("dec_opcode", {25'b0, dec_opcode}, {25'b0, e.instr[6:0]});
                    check32("dec_pc", dec_pc, e.pc);
                end
                if (exp_q.size() == 0) pend_seen = 1'b0;
            end else if (dec_valid && exp_q.size() == 0 && !redirect_valid) begin
                check32("unexpected_dec", {31'b0, dec_valid}, 32'd0);
            end
            prev_hold  = dec_valid && !dec_ready && !redirect_valid;
            prev_instr = dec_instruction;
            prev_opc   = dec_opcode;
            prev_pc    = dec_pc;
        end
    end

    task automatic wait_hs(input int n, input int budget);
        int target;
        int c;
        target = hs_count + n;
        c = 0;
        while (hs_count < target && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (hs_count < target) check32("timeout_handshake", hs_count, target);
    endtask

    // exact1: response due next cycle; otherwise at least two cycles away.
    task automatic wait_in_wait(input bit exact1);
        int c;
        c = 0;
        while (c < 100) begin
            @(negedge clk);
            #2;
            if (pending && !pend_stale && (exact1 ? (cnt == 1) : (cnt >= 2))) break;
            c++;
        end
        if (c >= 100) check32("timeout_wait_state", c, 0);
    endtask

    task automatic do_reset();
        rst_cycles = 2;
        repeat (4) @(negedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check32("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check32("rst_dec_instruction", dec_instruction, 32'h0000_0013);
        check32("rst_dec_opcode", {25'b0, dec_opcode}, 32'h13);
        check32("rst_dec_pc", dec_pc, TB_RESET_PC);
        check32("rst_req_addr", imem_req_addr, TB_RESET_PC);

        // Two back-to-back ADDI fetches, memory always ready, one-cycle response
        words_q.push_back(32'h0050_0093);
        words_q.push_back(32'h00A0_0113);
        wait_hs(2, 50);
        check32("basic_second_pc", last_hs_pc, 32'h4);

        // Decode back-pressure for five cycles
        do_reset();
        p_dready = 0;
        for (int i = 0; i < 50 && !dec_valid; i++) begin
            @(negedge clk);
            #2;
        end
        check32("bp_dec_valid", {31'b0, dec_valid}, 32'd1);
        repeat (5) @(negedge clk);
        p_dready = 100;
        wait_hs(2, 50);
        check32("bp_next_pc", last_hs_pc, 32'h4);

        // Redirect while waiting, response arrives later and is dropped
        do_reset();
        fixed_delay = 4;
        wait_in_wait(1'b0);
        force_target = 32'h0000_0102;
        force_redir  = 1'b1;
        wait_hs(1, 60);
        check32("drop_target_pc", last_hs_pc, 32'h0000_0100);

        // Redirect in the same cycle as the response
        do_reset();
        fixed_delay = 2;
        wait_in_wait(1'b1);
        force_target = 32'h0000_0200;
        force_redir  = 1'b1;
        wait_hs(1, 60);
        check32("same_cycle_target_pc", last_hs_pc, 32'h0000_0200);

        // PC wrap-around past the top of the address space
        do_reset();
        fixed_delay  = 1;
        force_target = 32'hFFFF_FFFE;
        force_redir  = 1'b1;
        wait_hs(1, 60);
        check32("wrap_first_pc", last_hs_pc, 32'hFFFF_FFFC);
        wait_hs(1, 60);
        check32("wrap_second_pc", last_hs_pc, 32'h0000_0000);

        // Reset while waiting; the late response must be ignored
        do_reset();
        fixed_delay = 4;
        wait_in_wait(1'b0);
        rst_cycles = 1;
        repeat (2) @(negedge clk);
        #2;
        check32("rst_wait_dec_valid", {31'b0, dec_valid}, 32'd0);
        check32("rst_wait_req_addr", imem_req_addr, TB_RESET_PC);
        wait_hs(1, 60);
        check32("rst_wait_next_pc", last_hs_pc, TB_RESET_PC);

        // Randomised traffic
        do_reset();
        fixed_delay = 0;
        p_ready = 60; p_dready = 60; p_redir = 8; p_spur = 10; p_rst = 3;
        repeat (3000) @(negedge clk);

        // Drain
        p_redir = 0; p_rst = 0; p_spur = 0; p_dready = 100; p_ready = 100;
        repeat (30) @(negedge clk);
        #2;
        check32("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
